panel_cmd_tx: RTL and testbench
===============================

PANEL_CMD_TX -- requirements
Module: panel_cmd_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 20, clocks per UART bit.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port cmd_valid  input  1  command request.
REQ-005 SHALL have port cmd_ready  output  1  command accepted on any edge where cmd_valid and cmd_ready are both high.
REQ-006 SHALL have port cmd_op  input  2  00 colour, 01 set pixel, 10 clear pixel, 11 clear screen.
REQ-007 SHALL have port cmd_arg  input  8  colour: rgb in [2:0]; pixel: {column[3:0], row[3:0]}; clear screen: ignored.
REQ-008 SHALL have port tx_out  output  1  UART serial line, idle high.
REQ-009 SHALL have port busy  output  1  high whenever a byte is in flight or pending.
REQ-010 SHALL have port done  output  1  one-cycle pulse at end of a command's last stop bit.

Function
REQ-011 SHALL send frames as 8N1: start bit low, 8 data bits LSB first, stop bit high, each bit exactly CLKS_PER_BIT cycles, so 10*CLKS_PER_BIT cycles per byte.
REQ-012 SHALL encode colour as one byte {5'b00000, cmd_arg[2:0]}; cmd_arg[7:3] ignored.
REQ-013 SHALL encode set pixel as 0x10 followed by cmd_arg, and clear pixel as 0x20 followed by cmd_arg.
REQ-014 SHALL encode clear screen as one byte 0x30.
REQ-015 SHALL send pixel argument 0xFF verbatim, with no flag or rejection.
REQ-016 SHALL register cmd_op and cmd_arg at acceptance; later input changes have no effect on the command in flight.
REQ-017 SHALL drive tx_out low for the start bit from the first edge after the acceptance edge (one cycle of latency).
REQ-018 SHALL send the second byte of a two-byte command immediately after the first stop bit, with no idle cycles.
REQ-019 SHALL use states IDLE, START, DATA, STOP: IDLE->START on accept; START->DATA after CLKS_PER_BIT; DATA->STOP after 8 bits; STOP->START if a byte is pending, else STOP->IDLE.
REQ-020 SHALL assert cmd_ready in IDLE and during the final cycle of the last stop bit of a command, so a back-to-back command starts its start bit with zero idle gap.
REQ-021 SHALL pulse done for one cycle, in the final cycle of the command's last stop bit.
REQ-022 SHALL keep busy low only in IDLE with no pending byte; busy equals the inverse of cmd_ready, except during the final stop-bit cycle where both are high.
REQ-023 SHALL use a bit-timing counter width of clog2(CLKS_PER_BIT) and a 3-bit data-bit index; both SHALL wrap only under FSM control.

Reset
REQ-024 SHALL, on the edge where reset is high, force the state to IDLE, tx_out=1, busy=0, done=0, clear pending bytes and counters, and abandon any frame in progress, leaving a truncated frame on the line.
REQ-025 SHALL assert cmd_ready=1 on the first cycle after reset deasserts (without PANEL_CMD_TX_SYNC_EN).

Configuration
REQ-026 SHALL, with macro PANEL_CMD_TX_SYNC_EN defined, send one sync byte 0xFF immediately after reset deasserts, holding cmd_ready=0 and busy=1 until its stop bit completes (no done pulse); this returns the panel receiver to its control state after a truncated frame.
REQ-027 SHALL, without PANEL_CMD_TX_SYNC_EN, send no sync byte, and SHALL contain no sync logic.

Verification
REQ-028 Colour: accept op=00, arg=0xFD -> byte 0x05 sent; tx_out low at cycles 1-20 after acceptance; done pulses at cycle 200; cmd_ready high again at cycle 200.
REQ-029 Set pixel: op=01, arg=0xA3 -> bytes 0x10 then 0xA3 sent contiguously over 400 cycles; done pulses exactly once, at cycle 400.
REQ-030 Back-to-back: op=11 accepted, cmd_valid held with op=10, arg=0x5C -> bytes 0x30, 0x20, 0x5C sent with no idle high gap between frames.
REQ-031 Input stability: change cmd_arg from 0x11 to 0x22 on the cycle after accepting op=01 -> byte 0x11 still sent.
REQ-032 Reset mid-frame: assert reset during data bit 4 of 0x10 -> tx_out=1 on the next cycle; with PANEL_CMD_TX_SYNC_EN, byte 0xFF is sent next and cmd_ready=0 for 200 cycles.
REQ-033 Parameter: CLKS_PER_BIT=4, op=00, arg=0x07 -> byte 0x07 sent in 40 cycles, each bit exactly 4 cycles.

Source files
------------

// File: rtl/panel_cmd_tx.sv
// Serialises panel commands as 8N1 UART bytes (one or two bytes per command).
// Optional macro PANEL_CMD_TX_SYNC_EN sends a 0xFF sync byte after every reset.
module panel_cmd_tx #(
    parameter int CLKS_PER_BIT = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_arg,
    output logic       tx_out,
    output logic       busy,
    output logic       done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]    state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [2:0]    bit_reg, bit_next;
    logic [7:0]    shift_reg, shift_next;
    logic          pend_reg, pend_next;
    logic [7:0]    pend_byte_reg, pend_byte_next;
    logic          tx_reg, tx_next;

    logic          bit_end;
    logic          last_stop;
    logic          accept;
    logic [7:0]    first_byte;
    logic          has_second;

    assign bit_end   = (cnt_reg == CNT_LAST);
    // Final cycle of the last stop bit of a command: the handover point.
    assign last_stop = (state_reg == STOP) && bit_end && !pend_reg;
    assign accept    = cmd_valid && cmd_ready;
    assign tx_out    = tx_reg;

`ifdef PANEL_CMD_TX_SYNC_EN
    logic sync_arm_reg;
    logic sync_act_reg;

    // arm: sync byte still to be launched; act: sync byte on the line.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_arm_reg <= 1'b1;
            sync_act_reg <= 1'b0;
        end else if ((state_reg == IDLE) && sync_arm_reg) begin
            sync_arm_reg <= 1'b0;
            sync_act_reg <= 1'b1;
        end else if ((state_reg == STOP) && bit_end && sync_act_reg) begin
            sync_act_reg <= 1'b0;
        end
    end

    assign cmd_ready = !(sync_arm_reg || sync_act_reg) && ((state_reg == IDLE) || last_stop);
    assign done      = last_stop && !sync_act_reg;
    assign busy      = (state_reg != IDLE) || (sync_arm_reg && !reset);
`else
    assign cmd_ready = (state_reg == IDLE) || last_stop;
    assign done      = last_stop;
    assign busy      = (state_reg != IDLE);
`endif

    always_comb begin
        first_byte = 8'h00;
        has_second = 1'b0;
        case (cmd_op)
            2'b00: first_byte = {5'b00000, cmd_arg[2:0]};
            2'b01: begin
                first_byte = 8'h10;
                has_second = 1'b1;
            end
            2'b10: begin
                first_byte = 8'h20;
                has_second = 1'b1;
            end
            2'b11: first_byte = 8'h30;
        endcase
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        bit_next       = bit_reg;
        shift_next     = shift_reg;
        pend_next      = pend_reg;
        pend_byte_next = pend_byte_reg;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next     = START;
                    cnt_next       = '0;
                    shift_next     = first_byte;
                    pend_next      = has_second;
                    pend_byte_next = cmd_arg;
                end
`ifdef PANEL_CMD_TX_SYNC_EN
                else if (sync_arm_reg) begin
                    state_next = START;
                    cnt_next   = '0;
                    shift_next = 8'hFF;
                    pend_next  = 1'b0;
                end
`endif
            end
            START: begin
                if (bit_end) begin
                    state_next = DATA;
                    cnt_next   = '0;
                    bit_next   = 3'd0;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_next = '0;
                    if (bit_reg == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_next   = bit_reg + 3'd1;
                        shift_next = {1'b0, shift_reg[7:1]};
                    end
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_next = '0;
                    if (pend_reg) begin
                        // Second byte follows the first stop bit with no gap.
                        state_next = START;
                        shift_next = pend_byte_reg;
                        pend_next  = 1'b0;
                    end else if (accept) begin
                        state_next     = START;
                        shift_next     = first_byte;
                        pend_next      = has_second;
                        pend_byte_next = cmd_arg;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
        endcase
    end

    // Line level is registered from the next state so it follows the FSM by one edge.
    always_comb begin
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            bit_reg       <= 3'd0;
            shift_reg     <= 8'h00;
            pend_reg      <= 1'b0;
            pend_byte_reg <= 8'h00;
            tx_reg        <= 1'b1;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            bit_reg       <= bit_next;
            shift_reg     <= shift_next;
            pend_reg      <= pend_next;
            pend_byte_reg <= pend_byte_next;
            tx_reg        <= tx_next;
        end
    end

endmodule

// File: tb/tb_panel_cmd_tx.sv
// Self-checking bench for panel_cmd_tx: directed protocol timing plus random
// commands compared against a per-cycle expected line waveform.
module tb_panel_cmd_tx;

    localparam int CPB = 20;
    localparam int TR  = 32768;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_arg = 8'h00;
    logic       cmd_ready, tx_out, busy, done;

    logic       v4 = 1'b0;
    logic [1:0] op4 = 2'b00;
    logic [7:0] arg4 = 8'h00;
    logic       ready4, tx4, busy4, done4;

    always #5 clk = ~clk;

    panel_cmd_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .tx_out(tx_out), .busy(busy), .done(done)
    );

    panel_cmd_tx #(.CLKS_PER_BIT(4)) dut4 (
        .clk(clk), .reset(reset), .cmd_valid(v4), .cmd_ready(ready4),
        .cmd_op(op4), .cmd_arg(arg4), .tx_out(tx4), .busy(busy4), .done(done4)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic tx_hist   [0:TR-1];
    logic done_hist [0:TR-1];
    logic exp_tx    [0:TR-1];
    logic exp_done  [0:TR-1];

    always @(negedge clk) begin
        if (cyc < TR) begin
            tx_hist[cyc]   <= tx_out;
            done_hist[cyc] <= done;
        end
    end

    int checks = 0;
    int errors = 0;
    int line_end = -1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Reference: a command becomes a list of bytes; each byte is 10 bits of
    // CPB cycles starting right after acceptance or after the previous command.
    task automatic model(input logic [1:0] op, input logic [7:0] arg, input int req, output int eacc);
        logic [7:0] bytes[$];
        int s;
        logic v;
        logic [7:0] by;
        bytes = {};
        case (op)
            2'b00: bytes.push_back({5'b00000, arg[2:0]});
            2'b01: begin bytes.push_back(8'h10); bytes.push_back(arg); end
            2'b10: begin bytes.push_back(8'h20); bytes.push_back(arg); end
            default: bytes.push_back(8'h30);
        endcase
        eacc = (req > line_end) ? req : line_end;
        s = eacc + 1;
        foreach (bytes[n]) begin
            by = bytes[n];
            for (int b = 0; b < 10; b++) begin
                if (b == 0)      v = 1'b0;
                else if (b == 9) v = 1'b1;
                else             v = by[b-1];
                for (int c = 0; c < CPB; c++)
                    if (s + b*CPB + c < TR) exp_tx[s + b*CPB + c] = v;
            end
            s = s + 10*CPB;
        end
        if (s - 1 < TR) exp_done[s-1] = 1'b1;
        line_end = s - 1;
    endtask

    task automatic send(input logic [1:0] op, input logic [7:0] arg, output int acc);
        int guard;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        guard     = 0;
        acc       = -1;
        while (!cmd_ready && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (cmd_ready) acc = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [7:0] arg, output int acc);
        int eacc;
        model(op, arg, cyc, eacc);
        send(op, arg, acc);
        $display("cmd op=%0d arg=%02h accepted at cycle %0d (expected %0d)", op, arg, acc, eacc);
        chk("accept_cycle", acc, eacc);
    endtask

    task automatic wait_cyc(input int t);
        int g;
        g = 0;
        while (cyc < t && g < 5000) begin
            @(negedge clk);
            g++;
        end
        if (cyc < t) chk("wait_timeout", cyc, t);
    endtask

    function automatic int bad_tx(input int lo, input int hi);
        int n;
        n = 0;
        for (int i = lo; i < hi; i++) if (tx_hist[i] !== exp_tx[i]) n++;
        return n;
    endfunction

    function automatic int bad_done(input int lo, input int hi);
        int n;
        n = 0;
        for (int i = lo; i < hi; i++) if (done_hist[i] !== exp_done[i]) n++;
        return n;
    endfunction

    initial begin
        int acc, acc2, sec_lo, nd, bad, dn_cnt, dn_at, k;
        logic ev;
        logic [7:0] b4;
        logic [1:0] rop;
        logic [7:0] rarg;

        for (int i = 0; i < TR; i++) begin
            exp_tx[i]   = 1'b1;
            exp_done[i] = 1'b0;
        end

        repeat (3) @(negedge clk);
        chk("rst_tx", tx_out, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", cmd_ready, 1'b1);
        chk("post_rst_busy", busy, 1'b0);
        chk("post_rst_ready4", ready4, 1'b1);

        // Colour command with absolute timing points.
        sec_lo = cyc;
        do_cmd(2'b00, 8'hFD, acc);
        wait_cyc(acc + 1);   chk("colour_start_first", tx_out, 1'b0);
        wait_cyc(acc + 20);  chk("colour_start_last", tx_out, 1'b0);
        wait_cyc(acc + 21);  chk("colour_bit0", tx_out, 1'b1);
        wait_cyc(acc + 100); chk("colour_mid_busy", busy, 1'b1);
                             chk("colour_mid_ready", cmd_ready, 1'b0);
        wait_cyc(acc + 199); chk("colour_done_early", done, 1'b0);
        wait_cyc(acc + 200); chk("colour_done", done, 1'b1);
                             chk("colour_ready_end", cmd_ready, 1'b1);
        wait_cyc(acc + 201); chk("colour_done_once", done, 1'b0);
                             chk("colour_idle_busy", busy, 1'b0);

        // Set pixel: two bytes, a single done at cycle 400.
        do_cmd(2'b01, 8'hA3, acc);
        wait_cyc(acc + 402);
        nd = 0;
        for (int i = acc + 1; i < acc + 402; i++) if (done_hist[i] === 1'b1) nd++;
        chk("pixel_done_count", nd, 1);
        chk("pixel_done_at_400", done_hist[acc+400], 1'b1);

        // Back-to-back: clear screen then clear pixel, valid held throughout.
        do_cmd(2'b11, 8'h99, acc);
        do_cmd(2'b10, 8'h5C, acc2);
        chk("b2b_accept_gap", acc2 - acc, 200);

        // Argument change after acceptance must not affect the frame.
        do_cmd(2'b01, 8'h11, acc);
        cmd_arg = 8'h22;
        wait_cyc(line_end + 3);
        chk("directed_tx_window", bad_tx(sec_lo, line_end + 2), 0);
        chk("directed_done_window", bad_done(sec_lo, line_end + 2), 0);

        // CLKS_PER_BIT = 4 instance.
        b4 = 8'h07;
        v4 = 1'b1; op4 = 2'b00; arg4 = 8'h07;
        chk("c4_ready", ready4, 1'b1);
        @(negedge clk);
        v4 = 1'b0;
        bad = 0; dn_cnt = 0; dn_at = -1;
        for (int i = 1; i <= 44; i++) begin
            k = (i - 1) / 4;
            if (k == 0)      ev = 1'b0;
            else if (k >= 9) ev = 1'b1;
            else             ev = b4[k-1];
            if (tx4 !== ev) bad++;
            if (done4 === 1'b1) begin dn_cnt++; dn_at = i; end
            @(negedge clk);
        end
        $display("cpb4 frame: bad_cycles=%0d done_count=%0d done_at=%0d", bad, dn_cnt, dn_at);
        chk("c4_frame", bad, 0);
        chk("c4_done_count", dn_cnt, 1);
        chk("c4_done_at_40", dn_at, 40);

        // Reset during data bit 4 of the 0x10 prefix, then during a start bit.
        do_cmd(2'b01, 8'h4B, acc);
        wait_cyc(acc + 1 + 5*CPB + 5);
        chk("rst_mid_bit4", tx_out, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_tx", tx_out, 1'b1);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_done", done, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_ready", cmd_ready, 1'b1);
        line_end = cyc - 1;
        do_cmd(2'b00, 8'h02, acc);
        wait_cyc(acc + 3);
        chk("rst_start_low", tx_out, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_start_tx", tx_out, 1'b1);
        reset = 1'b0;
        @(negedge clk);
        for (int i = cyc; i < TR; i++) begin
            exp_tx[i]   = 1'b1;
            exp_done[i] = 1'b0;
        end
        line_end = cyc - 1;

        // Random commands, mixing back-to-back and idle gaps.
        sec_lo = cyc;
        for (int n = 0; n < 14; n++) begin
            rop  = 2'($urandom_range(0, 3));
            rarg = 8'($urandom);
            if (n == 3) begin rop = 2'b01; rarg = 8'hFF; end
            do_cmd(rop, rarg, acc);
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(150, 450)) @(negedge clk);
        end
        wait_cyc(line_end + 3);
        chk("random_tx_window", bad_tx(sec_lo, line_end + 2), 0);
        chk("random_done_window", bad_done(sec_lo, line_end + 2), 0);
        chk("random_final_busy", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
